// File: rtl/bcd_display_scan_if.sv
// Display-side bus of bcd_display_scan: BCD word input with its load strobe,
// the segment/digit drive outputs, the frame pulse and a scan-state debug flag.
interface bcd_display_scan_if;
    // load is a plain strobe with no ready: bcd_in is taken on every rising
    // edge where load=1, and the display never stalls or refuses a word.
    logic [11:0] bcd_in;
    logic        load;
    logic [6:0]  seg;
    logic [2:0]  dig_sel;
    logic        frame_done;
    logic        scan_state;

    modport master (
        output bcd_in,
        output load,
        input  seg,
        input  dig_sel,
        input  frame_done,
        input  scan_state
    );

    modport slave (
        input  bcd_in,
        input  load,
        output seg,
        output dig_sel,
        output frame_done,
        output scan_state
    );
endinterface

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 3-digit seven-segment scanner with double-buffered input,
// one blank cycle between digits and frame-synchronous word updates.
// Optional leading-zero blanking is enabled by defining BCD_SCAN_LZB_EN.
module bcd_display_scan #(
    parameter int PRESCALE_W = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    bcd_display_scan_if.slave     bus_if
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [PRESCALE_W-1:0] DWELL_MAX = {PRESCALE_W{1'b1}};
    localparam logic [PRESCALE_W-1:0] DWELL_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [11:0]           active_q, active_d;
    logic [11:0]           shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [1:0]            digit_q, digit_d;
    logic [PRESCALE_W-1:0] dwell_q, dwell_d;
    logic [6:0]            seg_q, seg_d;
    logic [2:0]            dig_sel_q, dig_sel_d;
    logic                  frame_done_q, frame_done_d;

    logic                  boundary;
    logic [3:0]            nibble;
    logic                  lz_blank;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    assign boundary = (digit_q == 2'd2) && (dwell_q == DWELL_MAX);

    always_comb begin
        nibble = active_q[3:0];
        case (digit_q)
            2'd1:    nibble = active_q[7:4];
            2'd2:    nibble = active_q[11:8];
            default: nibble = active_q[3:0];
        endcase
    end

`ifdef BCD_SCAN_LZB_EN
    always_comb begin
        lz_blank = 1'b0;
        if (digit_q == 2'd2 && active_q[11:8] == 4'd0) begin
            lz_blank = 1'b1;
        end else if (digit_q == 2'd1 && active_q[11:4] == 8'd0) begin
            lz_blank = 1'b1;
        end
    end
`else
    assign lz_blank = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        digit_d      = digit_q;
        dwell_d      = dwell_q;
        seg_d        = 7'h00;
        dig_sel_d    = 3'b000;
        frame_done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus_if.load) begin
                    active_d = bus_if.bcd_in;
                    dwell_d  = '0;
                    digit_d  = 2'd0;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                dwell_d = dwell_q + DWELL_ONE;
                if (dwell_q == DWELL_MAX) begin
                    digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
                end

                // dwell==0 is the anti-ghosting gap: everything dark.
                if (dwell_q != '0) begin
                    dig_sel_d = 3'b001 << digit_q;
                    seg_d     = lz_blank ? 7'h00 : decode(nibble);
                end

                // A load on the boundary itself bypasses the shadow so it is
                // shown from the very next frame without waiting a whole frame.
                if (boundary) begin
                    frame_done_d = 1'b1;
                    if (bus_if.load) begin
                        active_d  = bus_if.bcd_in;
                        pending_d = 1'b0;
                    end else if (pending_q) begin
                        active_d  = shadow_q;
                        pending_d = 1'b0;
                    end
                end else if (bus_if.load) begin
                    shadow_d  = bus_if.bcd_in;
                    pending_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            active_q     <= 12'h000;
            shadow_q     <= 12'h000;
            pending_q    <= 1'b0;
            digit_q      <= 2'd0;
            dwell_q      <= '0;
            seg_q        <= 7'h00;
            dig_sel_q    <= 3'b000;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            digit_q      <= digit_d;
            dwell_q      <= dwell_d;
            seg_q        <= seg_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus_if.seg        = seg_q;
    assign bus_if.dig_sel    = dig_sel_q;
    assign bus_if.frame_done = frame_done_q;
    assign bus_if.scan_state = (state_q == ST_SCAN);

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan: directed scenarios plus random traffic checked
// against a frame-position model (position = cycles since scan start mod frame).
module tb_bcd_display_scan;

    localparam int PW    = 2;
    localparam int DWELL = 4;
    localparam int FRAME = 3 * DWELL;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_display_scan_if bus ();

    bcd_display_scan #(.PRESCALE_W(PW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    // Model: whether scanning, cycles since scan start, shown word, buffer.
    bit          m_scan;
    int          m_t;
    logic [11:0] m_active;
    logic [11:0] m_shadow;
    bit          m_pending;

    logic [10:0] exp_q[$];
    logic [10:0] exp;
    int          checks;
    int          errors;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic logic [6:0] digit_seg(input logic [11:0] w, input int d);
        logic [3:0] h, t, u;
        h = w[11:8];
        t = w[7:4];
        u = w[3:0];
`ifdef BCD_SCAN_LZB_EN
        if (d == 2 && h == 4'd0) return 7'h00;
        if (d == 1 && h == 4'd0 && t == 4'd0) return 7'h00;
`endif
        if (d == 2) return glyph(h);
        if (d == 1) return glyph(t);
        return glyph(u);
    endfunction

    function automatic logic [10:0] dut_out();
        return {bus.frame_done, bus.dig_sel, bus.seg};
    endfunction

    // Drive one cycle, predict the registered outputs, then sample #1 after the edge.
    task automatic step(input logic r, input logic ld, input logic [11:0] b);
        logic [10:0] e;
        int p, dg, dw;
        rst        = r;
        bus.load   = ld;
        bus.bcd_in = b;
        e = '0;
        if (r) begin
            m_scan = 0; m_t = 0; m_active = '0; m_shadow = '0; m_pending = 0;
        end else if (!m_scan) begin
            if (ld) begin
                m_scan = 1; m_t = 0; m_active = b;
            end
        end else begin
            p  = m_t % FRAME;
            dg = p / DWELL;
            dw = p % DWELL;
            e[10] = (p == FRAME - 1);
            if (dw != 0) begin
                e[9:7] = (dg == 0) ? 3'b001 : (dg == 1) ? 3'b010 : 3'b100;
                e[6:0] = digit_seg(m_active, dg);
            end
            if (p == FRAME - 1) begin
                if (ld) begin
                    m_active = b; m_pending = 0;
                end else if (m_pending) begin
                    m_active = m_shadow; m_pending = 0;
                end
            end else if (ld) begin
                m_shadow = b; m_pending = 1;
            end
            m_t++;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 12'h000);
        exp = exp_q.pop_front();
        checks++;
        if (dut_out() !== exp || exp !== 11'h000) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 000", dut_out());
        end
        checks++;
        if (bus.scan_state !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got %b expected 0", bus.scan_state);
        end
        repeat (3) begin
            step(1'b0, 1'b0, 12'h000);
            exp = exp_q.pop_front();
            checks++;
            if (dut_out() !== exp) begin
                errors++;
                $display("FAIL idle_blank: got %h expected %h", dut_out(), exp);
            end
        end
    endtask

    task automatic test_first_load();
        int first_on;
        int fd_cnt;
        first_on = -1;
        fd_cnt   = 0;
        step(1'b0, 1'b1, 12'h255);
        exp = exp_q.pop_front();
        checks++;
        if (dut_out() !== exp) begin
            errors++;
            $display("FAIL load_cycle: got %h expected %h", dut_out(), exp);
        end
        for (int k = 1; k <= 2 * FRAME; k++) begin
            step(1'b0, 1'b0, 12'h000);
            exp = exp_q.pop_front();
            checks++;
            if (dut_out() !== exp) begin
                errors++;
                $display("FAIL scan_255 k=%0d: got %h expected %h", k, dut_out(), exp);
            end
            if (first_on < 0 && bus.dig_sel != 3'b000) first_on = k;
            if (bus.frame_done === 1'b1) fd_cnt++;
        end
        checks++;
        if (first_on != 2) begin
            errors++;
            $display("FAIL first_digit_latency: got %0d expected 2", first_on);
        end
        checks++;
        if (fd_cnt != 2) begin
            errors++;
            $display("FAIL frame_done_count: got %0d expected 2", fd_cnt);
        end
    endtask

    task automatic test_word(input logic [11:0] w);
        step(1'b1, 1'b0, 12'h000);
        void'(exp_q.pop_front());
        step(1'b0, 1'b1, w);
        void'(exp_q.pop_front());
        for (int k = 0; k < 2 * FRAME; k++) begin
            step(1'b0, 1'b0, 12'h000);
            exp = exp_q.pop_front();
            checks++;
            if (dut_out() !== exp) begin
                errors++;
                $display("FAIL word_%h k=%0d: got %h expected %h", w, k, dut_out(), exp);
            end
        end
    endtask

    task automatic test_midframe_loads();
        int guard;
        test_word(12'h255);
        guard = 0;
        while (m_t % FRAME != 5 && guard < FRAME) begin
            step(1'b0, 1'b0, 12'h000);
            void'(exp_q.pop_front());
            guard++;
        end
        step(1'b0, 1'b1, 12'h123);
        void'(exp_q.pop_front());
        step(1'b0, 1'b1, 12'h456);
        void'(exp_q.pop_front());
        for (int k = 0; k < 2 * FRAME; k++) begin
            step(1'b0, 1'b0, 12'h000);
            exp = exp_q.pop_front();
            checks++;
            if (dut_out() !== exp) begin
                errors++;
                $display("FAIL midframe k=%0d: got %h expected %h", k, dut_out(), exp);
            end
        end
    endtask

    task automatic test_boundary_load();
        int guard;
        guard = 0;
        while (m_t % FRAME != FRAME - 1 && guard < FRAME) begin
            step(1'b0, 1'b0, 12'h000);
            void'(exp_q.pop_front());
            guard++;
        end
        step(1'b0, 1'b1, 12'h999);
        exp = exp_q.pop_front();
        checks++;
        if (dut_out() !== exp) begin
            errors++;
            $display("FAIL boundary_cycle: got %h expected %h", dut_out(), exp);
        end
        for (int k = 0; k < 2 * FRAME; k++) begin
            step(1'b0, 1'b0, 12'h000);
            exp = exp_q.pop_front();
            checks++;
            if (dut_out() !== exp) begin
                errors++;
                $display("FAIL boundary_999 k=%0d: got %h expected %h", k, dut_out(), exp);
            end
            if (exp[9:7] != 3'b000) begin
                checks++;
                if (bus.seg !== 7'h6F) begin
                    errors++;
                    $display("FAIL boundary_glyph k=%0d: got %h expected 6f", k, bus.seg);
                end
            end
        end
    endtask

    task automatic test_rst_midframe();
        int guard;
        guard = 0;
        while (m_t % FRAME != DWELL + 2 && guard < FRAME) begin
            step(1'b0, 1'b1, 12'h321);
            void'(exp_q.pop_front());
            guard++;
        end
        step(1'b1, 1'b0, 12'h000);
        exp = exp_q.pop_front();
        checks++;
        if (dut_out() !== 11'h000 || exp !== 11'h000) begin
            errors++;
            $display("FAIL rst_midframe: got %h expected 000", dut_out());
        end
        step(1'b1, 1'b1, 12'h777);
        void'(exp_q.pop_front());
        for (int k = 0; k < FRAME; k++) begin
            step(1'b0, 1'b0, 12'h000);
            exp = exp_q.pop_front();
            checks++;
            if (dut_out() !== exp || bus.scan_state !== 1'b0) begin
                errors++;
                $display("FAIL post_rst_blank k=%0d: got %h expected %h", k, dut_out(), exp);
            end
        end
    endtask

    task automatic test_random();
        logic r, ld;
        logic [11:0] b;
        for (int k = 0; k < 600; k++) begin
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 7) == 0);
            b  = 12'($urandom_range(0, 4095));
            step(r, ld, b);
            exp = exp_q.pop_front();
            checks++;
            if (dut_out() !== exp) begin
                errors++;
                $display("FAIL random k=%0d: got %h expected %h", k, dut_out(), exp);
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus.load   = 1'b0;
        bus.bcd_in = 12'h000;
        m_scan = 0; m_t = 0; m_active = '0; m_shadow = '0; m_pending = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_first_load();
        test_word(12'h007);
        test_word(12'hA3F);
        test_word(12'h000);
        test_word(12'h090);
        test_midframe_loads();
        test_boundary_load();
        test_rst_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
